// File: rtl/alu_seq_controller.sv
// Sequenced ALU controller: single-cycle logic/arith ops, plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module alu_seq_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       operation,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   // state  | meaning
   // IDLE   | waiting for start; single-cycle ops complete from here
   // MUL    | shift-add multiply, one multiplier bit per edge
   // DIV    | restoring divide, one quotient bit per edge
   // FINISH | publish iterative result, pulse done, return to IDLE
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH:0]   acc;
   logic [2:0]       op_code;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] fin_val;
   logic [WIDTH:0]   rem_sh, rem_diff;
   logic             last_iter;
   logic             iterative;

   always_comb begin
      operation = 3'b000;
      unique case (alu_op)
         2'b00: operation = 3'b010;
         2'b01: operation = 3'b110;
         2'b11: operation = 3'b111;
         default: begin
            unique case (func)
               6'b100000: operation = 3'b010;
               6'b100011: operation = 3'b110;
               6'b100100: operation = 3'b000;
               6'b100101: operation = 3'b001;
               6'b101010: operation = 3'b111;
               6'b011000: operation = 3'b011;
               6'b011010: operation = 3'b100;
               default:   operation = 3'b000;
            endcase
         end
      endcase
   end

   // Divide by zero never reaches this table's iterative path; it lands on 100 here.
   always_comb begin
      alu_out = '0;
      unique case (operation)
         3'b010:  alu_out = a + b;
         3'b110:  alu_out = a - b;
         3'b000:  alu_out = a & b;
         3'b001:  alu_out = a | b;
         3'b111:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b100:  alu_out = '1;
         default: alu_out = '0;
      endcase
   end

   assign iterative = (operation == 3'b011) || ((operation == 3'b100) && (b != '0));
   assign last_iter = (cnt == CW'(WIDTH - 1));
   assign rem_sh    = {acc[WIDTH-1:0], op_a[WIDTH-1]};
   assign rem_diff  = rem_sh - {1'b0, op_b};
   assign fin_val   = (op_code == 3'b011) ? acc[WIDTH-1:0] : op_a;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start && iterative) state_next = (operation == 3'b011) ? MUL : DIV;
         end
         MUL, DIV: begin
            if (last_iter) state_next = FINISH;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         acc     <= '0;
         op_code <= '0;
         cnt     <= '0;
         result  <= '0;
         zero    <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_a    <= a;
                  op_b    <= b;
                  op_code <= operation;
                  acc     <= '0;
                  cnt     <= '0;
                  if (!iterative) begin
                     result <= alu_out;
                     zero   <= (alu_out == '0);
                     done   <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (op_b[0]) acc <= {1'b0, acc[WIDTH-1:0] + op_a};
               op_a <= op_a << 1;
               op_b <= op_b >> 1;
               cnt  <= cnt + CW'(1);
            end
            DIV: begin
               // Borrow out of the trial subtraction means the divisor did not fit.
               if (!rem_diff[WIDTH]) begin
                  acc  <= rem_diff;
                  op_a <= {op_a[WIDTH-2:0], 1'b1};
               end else begin
                  acc  <= rem_sh;
                  op_a <= {op_a[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
            end
            default: begin
               result <= fin_val;
               zero   <= (fin_val == '0);
               done   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_controller.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops one entry per done pulse and checks value, zero flag and latency.
module tb_alu_seq_controller;
   logic        clk, rst, start;
   logic [1:0]  alu_op;
   logic [5:0]  func;
   logic [31:0] a, b;
   logic [2:0]  operation;
   logic [31:0] result;
   logic        zero, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic        z;
      int          issue;
      int          lat;
   } exp_t;
   exp_t sb[$];

   alu_seq_controller #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .func(func),
      .a(a), .b(b), .operation(operation), .result(result), .zero(zero),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("zero", 64'(zero), 64'(e.z));
            check("latency", 64'(cyc - e.issue), 64'(e.lat));
         end
      end
   end

   // Call at a negedge; returns at the following negedge with start dropped.
   task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] res, input logic z, input int lat);
      exp_t e;
      alu_op = op; func = fn; a = va; b = vb; start = 1'b1;
      e.res = res; e.z = z; e.issue = cyc + 1; e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (!busy && sb.size() == 0) ok = 1;
         else @(negedge clk);
      end
      if (!ok) check("wait_idle_timeout", 64'(sb.size()), 64'd0);
   endtask

   logic [1:0] dec_op [12] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
   logic [5:0] dec_fn [12] = '{6'h3F, 6'h20, 6'h00, 6'h20, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h3F, 6'h23};
   logic [2:0] dec_ex [12] = '{3'b010, 3'b110, 3'b111, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100, 3'b000, 3'b010};

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; alu_op = 2'b01; func = 6'h00; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_result", 64'(result), 64'd0);
      check("reset_zero", 64'(zero), 64'd1);
      check("reset_done", 64'(done), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("op_during_reset", 64'(operation), 64'd6);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         alu_op = dec_op[i]; func = dec_fn[i];
         #1 check("decode", 64'(operation), 64'(dec_ex[i]));
      end
      @(negedge clk);

      issue(2'b10, 6'h20, 32'd7, 32'd5, 32'd12, 1'b0, 0);
      check("add_busy", 64'(busy), 64'd0);
      issue(2'b01, 6'h00, 32'h1234, 32'h1234, 32'd0, 1'b1, 0);
      issue(2'b11, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
      issue(2'b10, 6'h23, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
      issue(2'b10, 6'h25, 32'hF0, 32'h0F, 32'hFF, 1'b0, 0);
      issue(2'b10, 6'h2A, 32'd5, 32'd3, 32'd0, 1'b1, 0);
      issue(2'b10, 6'h3F, 32'hFF, 32'h0F, 32'h0F, 1'b0, 0);
      issue(2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0);
      wait_idle();

      issue(2'b10, 6'h18, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 1'b0, 33);
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      check("mul_busy_cycles", 64'(n), 64'd33);
      wait_idle();

      issue(2'b10, 6'h1A, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      wait_idle();
      issue(2'b10, 6'h1A, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 33);
      wait_idle();
      issue(2'b10, 6'h1A, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
      check("div0_busy", 64'(busy), 64'd0);
      wait_idle();

      issue(2'b10, 6'h18, 32'd3, 32'd5, 32'd15, 1'b0, 33);
      n = 0;
      while (!done && n < 100) begin n++; @(negedge clk); end
      check("b2b_done_seen", 64'(done), 64'd1);
      issue(2'b10, 6'h24, 32'hF0, 32'h3C, 32'h30, 1'b0, 0);
      wait_idle();

      issue(2'b10, 6'h1A, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      repeat (3) @(negedge clk);
      alu_op = 2'b10; func = 6'h20; a = 32'd9; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_before_rst", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(2'b10, 6'h20, 32'd2, 32'd3, 32'd5, 1'b0, 0);
      wait_idle();
      repeat (40) @(negedge clk);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_seq_controller.md
ALU_SEQ_CONTROLLER -- requirements
Module: alu_seq_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the datapath width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port alu_op  input  2  instruction class: 00 lw/sw, 01 beq, 10 R-type, 11 slti.
REQ-006 The block SHALL have port func  input  6  R-type function field.
REQ-007 The block SHALL have ports a, b  input  WIDTH  operands.
REQ-008 The block SHALL have port operation  output  3  combinational legacy ALU code of the current alu_op/func.
REQ-009 The block SHALL have port result  output  WIDTH  registered result of the last completed operation.
REQ-010 The block SHALL have port zero  output  1  registered flag, 1 when result == 0.
REQ-011 The block SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-012 The block SHALL have port done  output  1  single-cycle pulse marking result/zero update.

Function
REQ-013 operation SHALL decode as: alu_op 00 -> 010; 01 -> 110; 11 -> 111; 10 with func 100000 -> 010, 100011 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 011000 -> 011 (mult), 011010 -> 100 (div), any other func -> 000.
REQ-014 Codes SHALL execute as: 010 add, 110 sub, 000 and, 001 or, 111 signed set-less-than (result 1 or 0, zero-extended), 011 unsigned multiply (low WIDTH bits), 100 unsigned divide (quotient).
REQ-015 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, FINISH; busy = (state != IDLE).
REQ-017 In IDLE with start=1 at edge k, operands and operation code SHALL be captured at edge k.
REQ-018 Single-cycle codes (010,110,000,001,111) SHALL write result and zero at edge k, done high for the cycle after edge k, FSM stays IDLE (latency 1).
REQ-019 Code 011 SHALL enter MUL: shift-add, one bit per edge, WIDTH iteration edges, then FINISH; result, zero written and done high on the FINISH->IDLE edge (total latency WIDTH+2 edges from k, inclusive of the FINISH edge).
REQ-020 Code 100 SHALL enter DIV: restoring division, one quotient bit per edge, WIDTH iterations, then FINISH, same timing as REQ-019.
REQ-021 Divide with b == 0 SHALL not enter DIV: result = all ones, zero = 0, done after 1 cycle as REQ-018.
REQ-022 start while busy SHALL be ignored; operand/opcode changes while busy SHALL not affect the running operation.
REQ-023 start in the cycle that done is high SHALL be accepted (back-to-back issue).
REQ-024 done SHALL be high for exactly one cycle per accepted operation; result and zero SHALL hold between completions.
REQ-025 An internal iteration counter SHALL be $clog2(WIDTH)+1 bits and SHALL reset to 0 on every entry to MUL/DIV.

Reset
REQ-026 On rst=1, asynchronously: state IDLE, result 0, zero 1, done 0, busy 0, counter 0, captured operands 0.
REQ-027 rst asserted mid-MUL/DIV SHALL abort the operation with no done pulse; first start after rst release SHALL be accepted normally.
REQ-028 operation SHALL be purely combinational and unaffected by rst.

Verification
REQ-029 WIDTH=32, alu_op=10, func=100000, a=7, b=5, start 1 cycle -> next cycle result=12, zero=0, done=1, busy=0.
REQ-030 alu_op=01, a=b=0x1234 -> result=0, zero=1, done one cycle; alu_op=11, a=0xFFFFFFFF, b=1 -> result=1.
REQ-031 func=011000, a=0x10000, b=0x10001 -> busy high 33 cycles, result=0x00010000 (low 32 bits), single done pulse.
REQ-032 func=011010, a=100, b=7 -> result=14 after DIV latency; repeat with b=0 -> result=0xFFFFFFFF, done after 1 cycle, busy never high.
REQ-033 Start DIV, pulse start with new operands at cycle 5, assert rst at cycle 10 -> second start ignored, on rst all outputs at reset values, no done; new add after release completes in 1 cycle.
REQ-034 Back-to-back: MUL completion with start asserted in done cycle for and (a=0xF0, b=0x3C) -> next cycle result=0x30, done=1.
